// File: rtl/micro_sequencer_if.sv
// Bus between the microcode control unit and the micro-address sequencer.
// The control unit (master) drives the microword fields and instruction bits, and the sequencer (slave) returns upc and stack status.
interface micro_sequencer_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 4
);
  localparam int SW = $clog2(DEPTH + 1);

  logic          stall;
  logic [2:0]    seq_op;
  logic [AW-1:0] seq_target;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          cond_met;
  logic [AW-1:0] upc;
  logic [SW-1:0] stack_depth;
  logic          stack_ovf;
  logic          stack_unf;
  logic          dispatch_err;

  modport master (
    output stall, seq_op, seq_target, Op, Funct, cond_met,
    input  upc, stack_depth, stack_ovf, stack_unf, dispatch_err
  );

  modport slave (
    input  stall, seq_op, seq_target, Op, Funct, cond_met,
    output upc, stack_depth, stack_ovf, stack_unf, dispatch_err
  );
endinterface

// File: rtl/micro_sequencer.sv
// Registered micro-address sequencer feeding the microcode ROM.
// Supports increment, jump, conditional jump, two dispatch tables, call/return through a LIFO, and stall hold.
module micro_sequencer #(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  micro_sequencer_if.slave bus
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'b000,
    OP_JUMP  = 3'b001,
    OP_DISP1 = 3'b010,
    OP_DISP2 = 3'b011,
    OP_CJUMP = 3'b100,
    OP_CALL  = 3'b101,
    OP_RET   = 3'b110,
    OP_FETCH = 3'b111
  } seq_op_e;

  // No valid/ready pair exists. Every non-stalled cycle consumes exactly one microword.
  // While stall=1, every register holds, whatever the value of seq_op.
  seq_op_e       op;
  logic [AW-1:0] upc_q, upc_nxt, upc_inc;
  logic [SW-1:0] depth_q, depth_nxt, top_idx;
  logic          ovf_q, unf_q, derr_q;
  logic          set_ovf, set_unf, set_derr, push;
  logic          full, empty;
  logic [AW-1:0] stack_mem [2**IW];
  logic          unused_funct;

  assign op           = seq_op_e'(bus.seq_op);
  assign upc_inc      = upc_q + 1'b1;
  assign full         = (depth_q == SW'(DEPTH));
  assign empty        = (depth_q == '0);
  assign top_idx      = depth_q - 1'b1;
  assign unused_funct = ^bus.Funct[4:1];

  always_comb begin
    upc_nxt   = upc_inc;
    depth_nxt = depth_q;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    set_derr  = 1'b0;
    push      = 1'b0;
    case (op)
      OP_JUMP: upc_nxt = bus.seq_target;
      OP_DISP1: begin
        case (bus.Op)
          2'b00:   upc_nxt = bus.Funct[5] ? AW'(7) : AW'(6);
          2'b01:   upc_nxt = AW'(2);
          2'b10:   upc_nxt = AW'(9);
          default: begin
            upc_nxt  = '0;
            set_derr = 1'b1;
          end
        endcase
      end
      OP_DISP2: upc_nxt = bus.Funct[0] ? AW'(3) : AW'(5);
      OP_CJUMP: if (bus.cond_met) upc_nxt = bus.seq_target;
      OP_CALL: begin
        if (full) begin
          upc_nxt = '0;
          set_ovf = 1'b1;
        end else begin
          push      = 1'b1;
          upc_nxt   = bus.seq_target;
          depth_nxt = depth_q + 1'b1;
        end
      end
      OP_RET: begin
        if (empty) begin
          upc_nxt = '0;
          set_unf = 1'b1;
        end else begin
          upc_nxt   = stack_mem[top_idx[IW-1:0]];
          depth_nxt = depth_q - 1'b1;
        end
      end
      OP_FETCH: upc_nxt = '0;
      default:  upc_nxt = upc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      derr_q  <= 1'b0;
    end else if (!bus.stall) begin
      upc_q   <= upc_nxt;
      depth_q <= depth_nxt;
      ovf_q   <= ovf_q | set_ovf;
      unf_q   <= unf_q | set_unf;
      derr_q  <= derr_q | set_derr;
    end
  end

  // Stack contents are don't-care after reset, so the storage itself has no reset.
  always_ff @(posedge clk) begin
    if (!reset && !bus.stall && push) stack_mem[depth_q[IW-1:0]] <= upc_inc;
  end

  assign bus.upc          = upc_q;
  assign bus.stack_depth  = depth_q;
  assign bus.stack_ovf    = ovf_q;
  assign bus.stack_unf    = unf_q;
  assign bus.dispatch_err = derr_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer. It runs directed test-plan steps followed by randomized cycles.
// Each cycle is checked against a queue-based model of the sequencer.
module tb_micro_sequencer;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  localparam logic [2:0] S_NEXT  = 3'd0;
  localparam logic [2:0] S_JUMP  = 3'd1;
  localparam logic [2:0] S_DISP1 = 3'd2;
  localparam logic [2:0] S_DISP2 = 3'd3;
  localparam logic [2:0] S_CJUMP = 3'd4;
  localparam logic [2:0] S_CALL  = 3'd5;
  localparam logic [2:0] S_RET   = 3'd6;
  localparam logic [2:0] S_FETCH = 3'd7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  micro_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) sif ();
  micro_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(sif));

  int checks   = 0;
  int failures = 0;

  int m_upc;
  int m_stack[$];
  bit m_ovf, m_unf, m_derr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit stl, input logic [2:0] op,
                            input int tgt, input int opf, input int fn, input bit cm);
    int nxt;
    if (rst) begin
      m_upc = 0;
      m_stack.delete();
      m_ovf = 0; m_unf = 0; m_derr = 0;
      return;
    end
    if (stl) return;
    nxt = (m_upc + 1) % (1 << AW);
    case (op)
      S_NEXT:  m_upc = nxt;
      S_JUMP:  m_upc = tgt;
      S_DISP1: begin
        if (opf == 0)      m_upc = fn[5] ? 7 : 6;
        else if (opf == 1) m_upc = 2;
        else if (opf == 2) m_upc = 9;
        else begin m_upc = 0; m_derr = 1; end
      end
      S_DISP2: m_upc = fn[0] ? 3 : 5;
      S_CJUMP: m_upc = cm ? tgt : nxt;
      S_CALL: begin
        if (m_stack.size() == DEPTH) begin m_upc = 0; m_ovf = 1; end
        else begin m_stack.push_back(nxt); m_upc = tgt; end
      end
      S_RET: begin
        if (m_stack.size() == 0) begin m_upc = 0; m_unf = 1; end
        else m_upc = m_stack.pop_back();
      end
      default: m_upc = 0;
    endcase
  endtask

  // One clock: drive inputs, advance the model, then compare every output 1 time unit after the edge.
  task automatic cyc(input string tag, input logic [2:0] op, input int tgt = 0,
                     input int opf = 0, input int fn = 0, input bit cm = 0,
                     input bit stl = 0, input bit rst = 0);
    reset          = rst;
    sif.stall      = stl;
    sif.seq_op     = op;
    sif.seq_target = tgt[AW-1:0];
    sif.Op         = opf[1:0];
    sif.Funct      = fn[5:0];
    sif.cond_met   = cm;
    model_step(rst, stl, op, tgt, opf, fn, cm);
    @(posedge clk);
    #1;
    chk({tag, ".upc"},   32'(sif.upc),          m_upc);
    chk({tag, ".depth"}, 32'(sif.stack_depth),  m_stack.size());
    chk({tag, ".ovf"},   32'(sif.stack_ovf),    32'(m_ovf));
    chk({tag, ".unf"},   32'(sif.stack_unf),    32'(m_unf));
    chk({tag, ".derr"},  32'(sif.dispatch_err), 32'(m_derr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sif.stall = 0; sif.seq_op = '0; sif.seq_target = '0;
    sif.Op = '0; sif.Funct = '0; sif.cond_met = 0;

    cyc("reset0", S_NEXT, .rst(1));
    cyc("reset1", S_NEXT, .rst(1));
    chk("reset_upc", 32'(sif.upc), 0);

    cyc("next1", S_NEXT); chk("next1_lit", 32'(sif.upc), 1);
    cyc("next2", S_NEXT); chk("next2_lit", 32'(sif.upc), 2);
    cyc("next3", S_NEXT); chk("next3_lit", 32'(sif.upc), 3);
    cyc("jump31", S_JUMP, 31);
    cyc("wrap", S_NEXT); chk("wrap_lit", 32'(sif.upc), 0);
    chk("wrap_noflag", {29'd0, sif.stack_ovf, sif.stack_unf, sif.dispatch_err}, 0);

    cyc("d1_ei", S_DISP1, 0, 0, 6'b100000); chk("d1_ei_lit", 32'(sif.upc), 7);
    cyc("d1_er", S_DISP1, 0, 0, 6'b000000); chk("d1_er_lit", 32'(sif.upc), 6);
    cyc("d1_mem", S_DISP1, 0, 1);           chk("d1_mem_lit", 32'(sif.upc), 2);
    cyc("d1_br", S_DISP1, 0, 2);            chk("d1_br_lit", 32'(sif.upc), 9);
    cyc("d1_err", S_DISP1, 0, 3);           chk("d1_err_lit", 32'(sif.dispatch_err), 1);
    for (int i = 0; i < 10; i++) cyc("derr_sticky", S_NEXT);
    chk("derr_sticky_lit", 32'(sif.dispatch_err), 1);

    cyc("d2_rd", S_DISP2, 0, 0, 6'b000001); chk("d2_rd_lit", 32'(sif.upc), 3);
    cyc("d2_wr", S_DISP2, 0, 0, 6'b000000); chk("d2_wr_lit", 32'(sif.upc), 5);
    cyc("cj_take", S_CJUMP, 12, 0, 0, 1);   chk("cj_take_lit", 32'(sif.upc), 12);
    cyc("cj_fall", S_CJUMP, 12, 0, 0, 0);   chk("cj_fall_lit", 32'(sif.upc), 13);

    cyc("rst_nest", S_NEXT, .rst(1));
    cyc("to4", S_JUMP, 4);
    cyc("call20", S_CALL, 20); chk("call20_depth", 32'(sif.stack_depth), 1);
    cyc("call25", S_CALL, 25); chk("call25_depth", 32'(sif.stack_depth), 2);
    cyc("ret21", S_RET);       chk("ret21_lit", 32'(sif.upc), 21);
    cyc("ret5", S_RET);        chk("ret5_lit", 32'(sif.upc), 5);
    cyc("ret_unf", S_RET);     chk("ret_unf_lit", 32'(sif.stack_unf), 1);

    cyc("rst_ovf", S_NEXT, .rst(1));
    cyc("to1", S_JUMP, 1);
    for (int i = 0; i < 4; i++) cyc("call_fill", S_CALL, 10 + i);
    chk("fill_depth", 32'(sif.stack_depth), 4);
    cyc("call_ovf", S_CALL, 14);
    chk("ovf_lit", {sif.stack_ovf, 26'd0, sif.upc}, {1'b1, 31'd0});
    chk("ovf_depth", 32'(sif.stack_depth), 4);
    cyc("ret13", S_RET); chk("ret13_lit", 32'(sif.upc), 13);
    cyc("ret12", S_RET); chk("ret12_lit", 32'(sif.upc), 12);
    cyc("ret11", S_RET); chk("ret11_lit", 32'(sif.upc), 11);
    cyc("ret2", S_RET);  chk("ret2_lit", 32'(sif.upc), 2);

    cyc("rst_b2b", S_NEXT, .rst(1));
    cyc("to3", S_JUMP, 3);
    cyc("b2b_call", S_CALL, 8);
    cyc("b2b_ret", S_RET); chk("b2b_ret_lit", 32'(sif.upc), 4);

    cyc("rst_stall", S_NEXT, .rst(1));
    cyc("stall_unf", S_RET, .stl(1)); chk("stall_unf_lit", 32'(sif.stack_unf), 0);
    cyc("to6", S_JUMP, 6);
    cyc("s_call20", S_CALL, 20);
    cyc("s_call22", S_CALL, 22);
    for (int i = 0; i < 3; i++) cyc("stall_call", S_CALL, 30, .stl(1));
    chk("stall_upc_lit", 32'(sif.upc), 22);
    chk("stall_depth_lit", 32'(sif.stack_depth), 2);
    cyc("stall_rst", S_CALL, 30, .stl(1), .rst(1));
    chk("stall_rst_lit", {sif.stack_depth, sif.upc}, 0);
    cyc("fetch", S_FETCH);

    for (int i = 0; i < 400; i++) begin
      cyc("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 31), $urandom_range(0, 3),
          $urandom_range(0, 63), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Registered micro-address sequencer directly upstream of the microcode ROM in the multicycle control unit. Each cycle it takes the next-address field of the current microword, the instruction's Op/Funct bits and the condition result, and produces the micro-address of the next microword. It supports the following address modes:
- increment
- jump
- conditional jump
- two decode dispatch tables
- call/return through a small hardware return stack
- memory-stall hold

## Interface
Parameters:
- AW, 5, micro-address width (ROM depth 2^AW)
- DEPTH, 4, return-stack entries (≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- stall  in  1  memory not ready; hold all state this cycle
- seq_op  in  3  next-address mode from current microword
- seq_target  in  AW  jump/call target from current microword
- Op  in  2  instruction op field from instruction register
- Funct  in  6  instruction funct field from instruction register
- cond_met  in  1  condition-check result for current instruction
- upc  out  AW  current micro-address, drives ROM address
- stack_depth  out  $clog2(DEPTH+1)  valid return-stack entries
- stack_ovf  out  1  sticky: CALL attempted with stack full
- stack_unf  out  1  sticky: RETURN attempted with stack empty
- dispatch_err  out  1  sticky: DISPATCH1 on Op=11

## Operation
- next = upc+1 is computed modulo 2^AW: 31 → 0 for AW=5, no flag.
- seq_op encodings. Each selects upc for the next cycle.
  - 000 NEXT: next.
  - 001 JUMP: seq_target.
  - 010 DISPATCH1 on Op:
    - 00 → Funct[5] ? 7 (ExecuteI) : 6 (ExecuteR)
    - 01 → 2 (MemAdr)
    - 10 → 9 (Branch)
    - 11 → 0, and set dispatch_err.
  - 011 DISPATCH2 on Funct[0]: 1 → 3 (MemRead), 0 → 5 (MemWrite).
  - 100 CJUMP: cond_met ? seq_target : next.
  - 101 CALL, stack not full: push next, go to seq_target, depth+1.
  - 101 CALL, stack full: no push, go to 0, set stack_ovf, depth unchanged.
  - 110 RETURN, stack not empty: pop, go to the popped address, depth−1.
  - 110 RETURN, stack empty: go to 0, set stack_unf.
  - 111 FETCH: go to 0; the stack is not cleared.
- Return stack is LIFO with storage DEPTH×AW. Entries above stack_depth are don't-care, and only valid entries are observable.
- stall=1 blocks all updates regardless of seq_op:
  - upc, stack contents, stack_depth and flags hold.
  - Sticky flags are not set during stall.
- Error flags are sticky: cleared only by reset, never by later operations.
- reset=1 overrides stall and seq_op. Next cycle:
  - upc=0, stack_depth=0, all flags 0
  - stack contents don't-care
- Reset mid-call discards all pending returns.

## Timing
- upc is a register. The ROM reads combinationally from upc, so seq_op/seq_target at cycle n determine upc at cycle n+1. One microinstruction per non-stalled cycle.
- Op, Funct and cond_met are sampled combinationally in the same cycle as seq_op. No internal registering.
- stack_depth and flags are registered and update on the same edge as upc.
- Push and pop each complete in one cycle. Back-to-back CALL/RETURN in consecutive cycles is legal: CALL at n, RETURN at n+1 → upc at n+2 = CALL address+1.
- After reset deassertion, the first ROM read is address 0 in that same cycle.

## Test plan
- Reset then NEXT ×3 → upc 0,1,2,3. Load upc=31 via JUMP, then NEXT → upc 0, no flags.
- DISPATCH1 checks:
  - Op=00, Funct=100000 → upc 7
  - Op=00, Funct=000000 → 6
  - Op=01 → 2; Op=10 → 9
  - Op=11 → 0, dispatch_err=1 and stays 1 through 10 further NEXT cycles.
- DISPATCH2: Funct=000001 → upc 3; Funct=000000 → upc 5. CJUMP target 12: cond_met=1 → 12; cond_met=0 from upc 12 → 13.
- Nested calls:
  - At upc 4, CALL 20 → 20, depth 1.
  - At 20, CALL 25 → 25, depth 2.
  - RETURN → 21. RETURN → 5, depth 0.
  - RETURN again → 0, stack_unf=1.
- Overflow (DEPTH=4): CALLs 10,11,12,13 from upcs 1,10,11,12 → depth 4. Fifth CALL 14 → upc 0, stack_ovf=1, depth 4. Then RETURN ×4 → 13,12,11,2.
- Stall: stall=1 for 3 cycles with seq_op=CALL → upc and depth unchanged. Reset asserted during stall with depth 2 → next cycle upc 0, depth 0, flags 0.
